// File: rtl/tmr_alarm.sv
// Millisecond alarm: counts down timer ticks from a programmed reload value and
// raises a sticky pending flag / interrupt on expiry, in one-shot or periodic mode.
module tmr_alarm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic        en_q, en_d;
  logic        periodic_q, periodic_d;
  logic        ie_q, ie_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic        ctrl_wr_s, reload_wr_s, status_wr_s;
  logic        expire_s;
  logic [31:0] next_reload_s;

  assign ctrl_wr_s   = stb && we && (addr == ADDR_CTRL);
  assign reload_wr_s = stb && we && (addr == ADDR_RELOAD);
  assign status_wr_s = stb && we && (addr == ADDR_STATUS);

  // A reload value written in the expiry cycle is the one a periodic alarm picks up.
  assign next_reload_s = reload_wr_s ? data_in : reload_q;

  // Next-state logic; a CTRL write suppresses any tick in the same cycle.
  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    reload_d   = reload_q;
    count_d    = count_q;
    pending_d  = pending_q;
    expire_s   = 1'b0;

    if (reload_wr_s) begin
      reload_d = data_in;
    end else begin
      reload_d = reload_q;
    end

    if (ctrl_wr_s) begin
      periodic_d = data_in[1];
      ie_d       = data_in[2];
      if (data_in[0] && (reload_q != 32'd0)) begin
        count_d = reload_q;
        en_d    = 1'b1;
      end else begin
        en_d = 1'b0;
      end
    end else if (en_q && tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        expire_s = 1'b1;
        if (periodic_q && (next_reload_s != 32'd0)) begin
          count_d = next_reload_s;
        end else begin
          count_d = 32'd0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end

    // Expiry beats a simultaneous software clear.
    if (expire_s) begin
      pending_d = 1'b1;
    end else if (status_wr_s && data_in[0]) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      reload_q   <= 32'd0;
      count_q    <= 32'd0;
      pending_q  <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
    end
  end

  // Read mux.
  always_comb begin
    data_out = 32'd0;
    case (addr)
      ADDR_CTRL:   data_out = {29'd0, ie_q, periodic_q, en_q};
      ADDR_RELOAD: data_out = reload_q;
      ADDR_COUNT:  data_out = count_q;
      ADDR_STATUS: data_out = {31'd0, pending_q};
      default:     data_out = 32'd0;
    endcase
  end

  assign ack = stb;
  assign irq = pending_q & ie_q;

endmodule

// File: tb/tb_tmr_alarm.sv
// Directed bench for tmr_alarm: hand-computed expectations checked with immediate assertions.
module tb_tmr_alarm;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;

  int n_tests;
  int n_fail;

  tmr_alarm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus/tick cycle: drive at negedge, release just after the rising edge.
  task automatic cyc(input logic s, input logic w, input logic [1:0] a,
                     input logic [31:0] d, input logic t);
    @(negedge clk);
    stb = s; we = w; addr = a; data_in = d; tick = t;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0; tick = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    check(tag, data_out, exp);
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  // n ticks, each followed by three idle cycles.
  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      repeat (3) @(posedge clk);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; tick = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
    repeat (2) @(posedge clk);
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_reload");
    rd(2'd2, 32'd0, "rst_count");
    rd(2'd3, 32'd0, "rst_status");
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd5);
    rd(2'd2, 32'd3, "os_count3");
    tk(1); rd(2'd2, 32'd2, "os_count2");
    tk(1); rd(2'd2, 32'd1, "os_count1");
    check("os_irq_pre", {31'd0, irq}, 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    check("os_irq", {31'd0, irq}, 32'd1);
    rd(2'd3, 32'd1, "os_pending");
    rd(2'd2, 32'd0, "os_count0");
    rd(2'd0, 32'd4, "os_ctrl");
    wr(2'd3, 32'd1);
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    rd(2'd3, 32'd0, "os_status_clr");

    // Periodic
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd7);
    for (int k = 0; k < 3; k++) begin
      tk(1);
      rd(2'd2, 32'd1, "per_count1");
      rd(2'd3, 32'd0, "per_nopend");
      tk(1);
      rd(2'd3, 32'd1, "per_pending");
      rd(2'd2, 32'd2, "per_reload");
      rd(2'd0, 32'd7, "per_ctrl");
      wr(2'd3, 32'd1);
      rd(2'd3, 32'd0, "per_clr");
    end

    // Collision: clear in expiry cycle
    tk(1);
    rd(2'd2, 32'd1, "col_count1");
    cyc(1'b1, 1'b1, 2'd3, 32'd1, 1'b1);
    rd(2'd3, 32'd1, "col_set_wins");
    rd(2'd2, 32'd2, "col_reloaded");
    wr(2'd3, 32'd1);

    // Collision: CTRL en=0 write in a tick cycle with count=1
    tk(1);
    cyc(1'b1, 1'b1, 2'd0, 32'd6, 1'b1);
    rd(2'd2, 32'd1, "col_ctrl_count");
    rd(2'd3, 32'd0, "col_ctrl_pend");
    rd(2'd0, 32'd6, "col_ctrl_rd");
    check("col_ctrl_irq", {31'd0, irq}, 32'd0);

    // Restart and reload corners
    wr(2'd1, 32'd9);
    wr(2'd0, 32'd5);
    tk(4);
    rd(2'd2, 32'd5, "rs_count5");
    wr(2'd0, 32'd5);
    rd(2'd2, 32'd9, "rs_restart");
    wr(2'd1, 32'd4);
    rd(2'd2, 32'd9, "rs_reload_wr");
    rd(2'd1, 32'd4, "rs_reload_rd");
    tk(1);
    rd(2'd2, 32'd8, "rs_dec");

    // Start with reload = 0 is rejected
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd5);
    rd(2'd0, 32'd4, "z_ctrl");
    tk(10);
    check("z_irq", {31'd0, irq}, 32'd0);
    rd(2'd2, 32'd8, "z_count");
    rd(2'd3, 32'd0, "z_pend");

    // Ticks while idle
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      @(posedge clk);
    end
    rd(2'd2, 32'd8, "idle_count");
    rd(2'd3, 32'd0, "idle_pend");

    // Asynchronous reset mid-run with pending set
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd7);
    tk(3);
    check("ar_irq_pre", {31'd0, irq}, 32'd1);
    tk(1);
    rd(2'd2, 32'd2, "ar_count_pre");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, 32'd0, "ar_ctrl");
    rd(2'd1, 32'd0, "ar_reload");
    rd(2'd2, 32'd0, "ar_count");
    rd(2'd3, 32'd0, "ar_status");
    @(negedge clk);
    stb = 1'b1;
    #1;
    check("ar_ack1", {31'd0, ack}, 32'd1);
    stb = 1'b0;
    #1;
    check("ar_ack0", {31'd0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
